booth_mult_scheduler: RTL
=========================

Name: booth_mult_scheduler

Overview:
- Upstream feeder for the 8x8 Booth multiplier.
- Accepts a stream of operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Issues jobs one at a time to the multiplier's start/ready handshake, captures each 16-bit product, and presents results over a valid/ready output interface.
- Sits between the operand source and the Booth multiplier; also owns result buffering.

Parameters:
- DATA_W, 8, operand width; product width is 2*DATA_W.
- FIFO_DEPTH, 4, operand-pair FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset. The system top drives the multiplier's active-low reset from ~reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  DATA_W  operand A, two's complement.
- in_b  in  DATA_W  operand B, two's complement.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  DATA_W  operand A to the multiplier; registered.
- mul_b  out  DATA_W  operand B to the multiplier; registered.
- mul_ready  in  1  multiplier idle flag.
- mul_product  in  2*DATA_W  multiplier product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_product  out  2*DATA_W  captured product.
- out_error  out  1  result is a watchdog abort; 0 unless the optional feature is compiled in.
- pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values:
  - FIFO empty; pending=0; in_ready=1.
  - mul_start=0; mul_a=0; mul_b=0.
  - out_valid=0; out_product=0; out_error=0.
  - state=IDLE.
- Reset during any state discards the in-flight job and all FIFO contents.
- FIFO push occurs when in_valid && in_ready.
  - in_ready depends only on full; a push is refused when full even if a pop happens in the same cycle.
- The head entry stays in the FIFO until its product is captured. The pop happens in the capture cycle.
- States:
  - IDLE: go to ISSUE when FIFO is non-empty and the output slot is free. The slot is free when out_valid==0, or out_valid && out_ready in this cycle. On the transition, load mul_a/mul_b from the FIFO head.
  - ISSUE: mul_start=1 for exactly this one cycle; next state is WAIT_BUSY.
  - WAIT_BUSY: wait for mul_ready==0, then go to WAIT_DONE. mul_start=0.
  - WAIT_DONE: wait for mul_ready==1. In that cycle: out_product<=mul_product, out_valid<=1, out_error<=0, pop FIFO, next state IDLE.
- mul_a and mul_b hold stable from ISSUE through capture. The multiplier samples on negedge, and a posedge-to-posedge pulse spans exactly one negedge.
- Output register:
  - out_valid holds until out_ready.
  - out_product and out_error are stable while out_valid=1.
  - A new capture may coincide with consumption of the old result.
- Minimum latency:
  - in_valid into an empty block to ISSUE: 2 cycles.
  - Each job: 3 cycles plus the multiplier's busy time.
- pending updates in the same cycle as push/pop. A simultaneous push and pop leaves it unchanged.
- No arithmetic is performed here. Products pass through bit-exact.

Optional Feature:
- Macro BOOTH_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A counter resets on entry to WAIT_BUSY and counts through WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: capture out_product=0 and out_error=1, pop the FIFO, return to IDLE.
  - A later mul_ready edge from the aborted job is ignored because the FSM is in IDLE or ISSUE.
- Without the macro: the block waits indefinitely; out_error is tied to 0 and no counter is synthesized.

Decomposition:
- Package booth_sched_pkg holds:
  - the state encoding constants IDLE, ISSUE, WAIT_BUSY, WAIT_DONE;
  - the DATA_W default;
  - a product-width function.
- One sub-module: sync_fifo, a parameterized width/depth synchronous FIFO with full, empty and count outputs. It stores {a,b}.

Test Plan:
- Push (3,5); multiplier model busy 9 cycles -> one mul_start pulse; mul_a=3, mul_b=5 stable until capture; out_product=0x000F, out_valid=1.
- Push (-2,7) and (-128,-128) back-to-back, out_ready=1 -> results 0xFFF2 then 0x4000 in order; exactly two start pulses.
- out_ready=0, in_valid=1 continuously -> exactly 5 pairs accepted; in_ready then stays 0; out_valid=1 with the first product; pending=4.
- Assert reset in WAIT_DONE -> next cycle all outputs are at reset values; pending=0; no capture when mul_ready later rises.
- With BOOTH_SCHED_TIMEOUT_EN and mul_ready stuck at 1 after start -> after 64 cycles: out_valid=1, out_error=1, out_product=0; the next job issues normally.
- Result consumed in the same cycle the next job is captured -> no lost or duplicated result; sequence order is preserved.

Source files
------------

// File: rtl/booth_sched_pkg.sv
// Shared types and constants for the Booth multiplier scheduler.
// Optional watchdog is enabled by defining BOOTH_SCHED_TIMEOUT_EN.
package booth_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    localparam int DEFAULT_DATA_W = 8;

    function automatic int prod_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Parameterized synchronous FIFO; head entry is visible on 'head' whenever not empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Feeds operand pairs from a FIFO to the Booth multiplier one job at a time and buffers the product.
// Define BOOTH_SCHED_TIMEOUT_EN to add a watchdog that aborts a hung job with out_error=1.
module booth_mult_scheduler
    import booth_sched_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_a,
    input  logic [DATA_W-1:0]             in_b,
    output logic                          mul_start,
    output logic [DATA_W-1:0]             mul_a,
    output logic [DATA_W-1:0]             mul_b,
    input  logic                          mul_ready,
    input  logic [prod_width(DATA_W)-1:0] mul_product,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [prod_width(DATA_W)-1:0] out_product,
    output logic                          out_error,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    sched_state_t          state;
    logic [2*DATA_W-1:0]   head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  capture;
    logic                  abort;
    logic                  slot_free;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign capture   = (state == WAIT_DONE) && mul_ready;
    assign pop       = capture || abort;

    sync_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({in_a, in_b}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

`ifdef BOOTH_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;
    logic          error_q;

    // A real completion in the same cycle as the limit wins over the abort.
    assign abort = ((state == WAIT_BUSY) || (state == WAIT_DONE)) && !capture &&
                   (timer == TW'(TIMEOUT_CYCLES - 1));
    assign out_error = error_q;
`else
    assign abort     = 1'b0;
    assign out_error = 1'b0;
`endif

    // Head stays in the FIFO until its result lands in the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
`ifdef BOOTH_SCHED_TIMEOUT_EN
            timer       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty && slot_free) begin
                        mul_a     <= head[2*DATA_W-1:DATA_W];
                        mul_b     <= head[DATA_W-1:0];
                        mul_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
`ifdef BOOTH_SCHED_TIMEOUT_EN
                    timer <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (!mul_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    state <= state;
                end
                default: state <= IDLE;
            endcase

            if (capture) begin
                out_valid   <= 1'b1;
                out_product <= mul_product;
                state       <= IDLE;
`ifdef BOOTH_SCHED_TIMEOUT_EN
                error_q     <= 1'b0;
`endif
            end

`ifdef BOOTH_SCHED_TIMEOUT_EN
            if ((state == WAIT_BUSY) || (state == WAIT_DONE)) begin
                timer <= timer + 1'b1;
            end
            if (abort) begin
                out_valid   <= 1'b1;
                out_product <= '0;
                error_q     <= 1'b1;
                state       <= IDLE;
            end
`endif
        end
    end

endmodule
